// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM fader: duty width, FSM states and
// the position of each colour field inside the 24-bit colour word.
package rgb_pkg;

    localparam int DUTY_W    = 8;
    localparam int NUM_CH    = 3;
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fsm_state_t;

    // Channel index 0 = red, 1 = green, 2 = blue.
    function automatic int ch_lsb(input int ch);
        case (ch)
            0:       return RED_LSB;
            1:       return GREEN_LSB;
            default: return BLUE_LSB;
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: working duty that steps toward the target, an active
// duty that only changes at the end of a PWM period, and the registered
// compare against the shared PWM counter.
module pwm_channel
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step_i,
    input  logic [DUTY_W-1:0] target_i,
    input  logic [DUTY_W-1:0] cnt_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] work_q;
    logic [DUTY_W-1:0] work_d;
    logic [DUTY_W-1:0] active_q;
    logic              pwm_q;

    // Move one count toward the target on a step; comparisons keep it in range.
    always_comb begin
        work_d = work_q;
        if (step_i) begin
            if (work_q < target_i) begin
                work_d = work_q + DUTY_W'(1);
            end else if (work_q > target_i) begin
                work_d = work_q - DUTY_W'(1);
            end
        end
    end

    // Duty registers and PWM output; active duty reloads only at count 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q   <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            work_q <= work_d;
            if (cnt_i == {DUTY_W{1'b1}}) begin
                active_q <= work_q;
            end
            pwm_q <= (cnt_i < active_q);
        end
    end

    assign duty_o = work_q;
    assign pwm_o  = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: accepts a target colour, steps the three duties toward it
// once every STEP_DIV clocks, and drives three 256-clock PWM outputs.
module rgb_pwm_fader
    import rgb_pkg::*;
#(
    parameter int CLK_HZ   = 48000000,
    parameter int STEP_DIV = 187500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        color_valid,
    output logic        color_ready,
    input  logic [23:0] color_rgb,
    output logic        red_pwm,
    output logic        green_pwm,
    output logic        blue_pwm,
    output logic        fade_done
);

    localparam logic [23:0] PRESC_MAX = 24'(STEP_DIV - 1);

    if (STEP_DIV < 1 || STEP_DIV > 16777215 || CLK_HZ <= 0) begin : g_bad_param
        $error("rgb_pwm_fader: STEP_DIV must be 1..2^24-1 and CLK_HZ positive");
    end

    fsm_state_t        state_q;
    fsm_state_t        state_d;
    logic [DUTY_W-1:0] cnt_q;
    logic [23:0]       presc_q;
    logic [23:0]       presc_d;
    logic [23:0]       target_q;
    logic [23:0]       target_d;
    logic              step_tick;
    logic              all_equal;
    logic [NUM_CH-1:0] eq_vec;
    logic [NUM_CH-1:0] pwm_vec;
    logic [DUTY_W-1:0] duty [NUM_CH];

    assign step_tick = (state_q == FADE) && (presc_q == PRESC_MAX);
    assign all_equal = &eq_vec;

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam int LSB = ch_lsb(gi);

        pwm_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .step_i   (step_tick),
            .target_i (target_q[LSB +: DUTY_W]),
            .cnt_i    (cnt_q),
            .duty_o   (duty[gi]),
            .pwm_o    (pwm_vec[gi])
        );

        assign eq_vec[gi] = (duty[gi] == target_q[LSB +: DUTY_W]);
    end

    assign red_pwm   = pwm_vec[0];
    assign green_pwm = pwm_vec[1];
    assign blue_pwm  = pwm_vec[2];

    // Next-state logic: accept in IDLE, count steps in FADE, finish when all match.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        target_d    = target_q;
        color_ready = 1'b0;
        fade_done   = 1'b0;
        case (state_q)
            IDLE: begin
                color_ready = 1'b1;
                if (color_valid) begin
                    target_d = color_rgb;
                    presc_d  = '0;
                    state_d  = FADE;
                end
            end
            FADE: begin
                if (all_equal) begin
                    fade_done = 1'b1;
                    presc_d   = '0;
                    state_d   = IDLE;
                end else if (step_tick) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, prescaler, target and free-running PWM counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            target_q <= target_d;
            cnt_q    <= cnt_q + DUTY_W'(1);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: a closed-form model of the fade and PWM timing
// checked every cycle on a STEP_DIV=4 instance, plus a directed run on a
// STEP_DIV=1 instance.
module tb_rgb_pwm_fader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid_m = 1'b0;
    logic [23:0] rgb_m   = '0;
    logic        ready_m, r_m, g_m, b_m, done_m;

    logic        valid_f = 1'b0;
    logic [23:0] rgb_f   = '0;
    logic        ready_f, r_f, g_f, b_f, done_f;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rgb_pwm_fader #(.CLK_HZ(48000000), .STEP_DIV(S)) u_main (
        .clk(clk), .rst(rst), .color_valid(valid_m), .color_ready(ready_m),
        .color_rgb(rgb_m), .red_pwm(r_m), .green_pwm(g_m), .blue_pwm(b_m),
        .fade_done(done_m)
    );

    rgb_pwm_fader #(.CLK_HZ(48000000), .STEP_DIV(1)) u_fast (
        .clk(clk), .rst(rst), .color_valid(valid_f), .color_ready(ready_f),
        .color_rgb(rgb_f), .red_pwm(r_f), .green_pwm(g_f), .blue_pwm(b_f),
        .fade_done(done_f)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model of the STEP_DIV=4 instance ----------
    // n counts clock edges since reset release. A fade accepted at edge acc
    // from duties st[] to tg[] has moved min(|tg-st|, (n-acc)/S) counts by
    // cycle n, and signals done at cycle acc + S*max|tg-st|. The duty seen on
    // a pin during one 256-clock period is the working duty at the last cycle
    // of the previous period, and the pin is high while the phase is below it.
    int    n, acc, d;
    bit    have;
    int    st [3];
    int    tg [3];
    int    act_prev [3];
    int    saved [3];
    string nm [3] = '{"red_pwm", "green_pwm", "blue_pwm"};

    always @(negedge clk) begin : mon
        int w_now [3];
        int diff, mag, steps, done_cyc, a;
        bit busy_n;
        logic [2:0] pv;
        pv = {b_m, g_m, r_m};
        if (rst) begin
            n = 0; have = 0; acc = 0; d = 0;
            for (int c = 0; c < 3; c++) begin
                st[c] = 0; tg[c] = 0; act_prev[c] = 0; saved[c] = 0;
            end
            chk("rst_pwm", int'(pv), 0);
            chk("rst_ready", int'(ready_m), 1);
            chk("rst_done", int'(done_m), 0);
        end else begin
            n++;
            steps = (n - acc) / S;
            for (int c = 0; c < 3; c++) begin
                diff = tg[c] - st[c];
                mag  = (diff < 0) ? -diff : diff;
                if (mag > steps) mag = steps;
                w_now[c] = st[c] + ((diff < 0) ? -mag : mag);
            end
            done_cyc = acc + d * S;
            busy_n   = have && (n <= done_cyc);
            for (int c = 0; c < 3; c++) begin
                chk(nm[c], int'(pv[c]), int'(((n - 1) % 256) < act_prev[c]));
                a = ((n % 256) == 0) ? saved[c] : act_prev[c];
                act_prev[c] = a;
                if ((n % 256) == 255) saved[c] = w_now[c];
            end
            chk("color_ready", int'(ready_m), int'(!busy_n));
            chk("fade_done", int'(done_m), int'(busy_n && (n == done_cyc)));
            if (!busy_n && valid_m) begin
                d = 0;
                for (int c = 0; c < 3; c++) begin
                    st[c] = w_now[c];
                    tg[c] = int'((rgb_m >> (16 - 8 * c)) & 24'hFF);
                    diff  = tg[c] - st[c];
                    mag   = (diff < 0) ? -diff : diff;
                    if (mag > d) d = mag;
                end
                acc  = n + 1;
                have = 1;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic [23:0] c);
        int i;
        @(posedge clk); #2;
        valid_m = 1'b1;
        rgb_m   = c;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready_m) break;
        end
        if (i >= 3000) begin
            total++;
            $display("FAIL send_timeout: got no color_ready within 3000 cycles");
        end
        @(posedge clk); #2;
        valid_m = 1'b0;
        rgb_m   = 24'($urandom);
    endtask

    task automatic wait_done(output int k);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_m) break;
        end
        if (i >= 2000) begin
            total++;
            $display("FAIL done_timeout: got no fade_done within 2000 cycles");
        end
        k = i;
    endtask

    // ---------------- main sequence -------------------------------------------
    initial begin
        int k, hr, hg, hb;
        logic [23:0] c;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // STEP_DIV=1 instance: full red fade while the main instance sits idle.
        @(posedge clk); #2;
        valid_f = 1'b1;
        rgb_f   = 24'hFF0000;
        @(posedge clk); #2;
        valid_f = 1'b0;
        rgb_f   = 24'h00FFFF;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) chk("fast_busy", int'(ready_f), 0);
            if (done_f) break;
        end
        chk("fast_done_lat", k, 255);
        @(negedge clk);
        chk("fast_done_pulse", int'(done_f), 0);
        chk("fast_ready_back", int'(ready_f), 1);
        repeat (300) @(negedge clk);
        hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hr += int'(r_f); hg += int'(g_f); hb += int'(b_f);
        end
        chk("fast_red_duty", hr, 255);
        chk("fast_green_duty", hg, 0);
        chk("fast_blue_duty", hb, 0);
        repeat (300) @(negedge clk);
        chk("idle_ready", int'(ready_m), 1);

        // Blue up to 0x80 then down to 0x40.
        send(24'h000080);
        wait_done(k);
        chk("fade80_lat", k, 128 * S);
        send(24'h000040);
        wait_done(k);
        chk("fade40_lat", k, 256);

        // Fade to 0x102030, then resend the same colour.
        send(24'h102030);
        wait_done(k);
        chk("fade102030_lat", k, 32 * S);
        repeat (600) @(negedge clk);
        send(24'h102030);
        wait_done(k);
        chk("resend_lat", k, 0);
        repeat (300) @(negedge clk);

        // Second colour offered while the first is still fading.
        send(24'h203040);
        send(24'h102030);
        wait_done(k);
        chk("held_fade_lat", k, 16 * S);

        // Random colours with random gaps, sometimes overlapping a fade.
        for (int r = 0; r < 6; r++) begin
            c = 24'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(c);
            if ($urandom_range(0, 1) == 0) wait_done(k);
        end
        wait_done(k);
        repeat (600) @(negedge clk);

        // Reset around step 100 of a 0 -> 255 red fade.
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        send(24'hFF0000);
        repeat (400) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_red", int'(r_m), 0);
        chk("rst_async_ready", int'(ready_m), 1);
        @(negedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", int'(ready_m), 1);
        repeat (600) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
